// File: rtl/counter_bank.sv
// Bank of CHANNELS up/down counters, each with its own limit register and
// a one-cycle boundary pulse. Define COUNTER_BANK_IRQ_EN to add sticky
// per-channel status and a registered interrupt output.

module counter_bank_ch #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             cnt_we_i,
  input  logic             lim_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    ovf_d = 1'b0;
    // A count write owns the cycle; counting compares against the old limit.
    if (cnt_we_i) begin
      cnt_d = wdata_i;
    end else if (en_i) begin
      if (up_i) begin
        if (cnt_q < lim_q) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? cnt_q : '0;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? '0 : lim_q;
        end
      end
    end
    if (lim_we_i) lim_d = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '1;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module counter_bank #(
  parameter int CH_AW    = 2,
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0,
  localparam int CHANNELS = 1 << CH_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] up,
  input  logic                we,
  input  logic                wlim,
  input  logic [CH_AW-1:0]    waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [CH_AW-1:0]    raddr,
  output logic [WIDTH-1:0]    rdata,
`ifdef COUNTER_BANK_IRQ_EN
  input  logic [CHANNELS-1:0] irq_clr,
  output logic                irq,
`endif
  output logic [CHANNELS-1:0] ovf
);
  logic [CHANNELS-1:0][WIDTH-1:0] cnt;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel = we && (waddr == CH_AW'(g));
    counter_bank_ch #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en[g]),
      .up_i     (up[g]),
      .cnt_we_i (sel && !wlim),
      .lim_we_i (sel && wlim),
      .wdata_i  (wdata),
      .cnt_o    (cnt[g]),
      .ovf_o    (ovf[g])
    );
  end

  assign rdata = cnt[raddr];

`ifdef COUNTER_BANK_IRQ_EN
  // Status latches the visible ovf pulse; a clear in that same cycle loses.
  logic [CHANNELS-1:0] status_q, status_d;
  logic                irq_q;

  assign status_d = (status_q & ~irq_clr) | ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |status_d;
    end
  end

  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: wrap and saturate instances side by side, checked
// against a behavioural model, a directed table, and directed corner cases.

module tb_counter_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  en = '0, up = '0;
  logic        we = 1'b0, wlim = 1'b0;
  logic [1:0]  waddr = '0, raddr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata0, rdata1;
  logic [3:0]  ovf0, ovf1;
`ifdef COUNTER_BANK_IRQ_EN
  logic [3:0]  irq_clr = '0;
  logic        irq0, irq1;
`endif

  always #5 clk = ~clk;

  counter_bank #(.CH_AW(2), .WIDTH(16), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .we(we), .wlim(wlim),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata0),
`ifdef COUNTER_BANK_IRQ_EN
    .irq_clr(irq_clr), .irq(irq0),
`endif
    .ovf(ovf0));

  counter_bank #(.CH_AW(2), .WIDTH(16), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .we(we), .wlim(wlim),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata1),
`ifdef COUNTER_BANK_IRQ_EN
    .irq_clr(irq_clr), .irq(irq1),
`endif
    .ovf(ovf1));

  // Reference model: index 0 = wrap instance, 1 = saturate instance
  int m_cnt [2][4];
  int m_lim [2][4];
  bit m_ovf [2][4];
  bit m_st  [2][4];
  bit m_irq [2];

  int n_vec = 0, n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 4; c++) begin
        m_cnt[s][c] = 0; m_lim[s][c] = 65535; m_ovf[s][c] = 0; m_st[s][c] = 0;
      end
      m_irq[s] = 0;
    end
  endtask

  task automatic model_step();
    for (int s = 0; s < 2; s++) begin
      bit any = 0;
      for (int c = 0; c < 4; c++) begin
        int cur = m_cnt[s][c], lim = m_lim[s][c], nxt = m_cnt[s][c];
        bit hit = 0;
        if (we && !wlim && waddr == c) nxt = wdata;
        else if (en[c] && up[c]) begin
          if (cur < lim) nxt = cur + 1;
          else begin hit = 1; nxt = (s == 1) ? cur : 0; end
        end else if (en[c]) begin
          if (cur > 0) nxt = cur - 1;
          else begin hit = 1; nxt = (s == 1) ? 0 : lim; end
        end
`ifdef COUNTER_BANK_IRQ_EN
        m_st[s][c] = (m_st[s][c] && !irq_clr[c]) || m_ovf[s][c];
`endif
        any = any | m_st[s][c];
        m_cnt[s][c] = nxt & 16'hFFFF;
        m_ovf[s][c] = hit;
        if (we && wlim && waddr == c) m_lim[s][c] = wdata;
      end
      m_irq[s] = any;
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] e0, e1;
    for (int c = 0; c < 4; c++) begin e0[c] = m_ovf[0][c]; e1[c] = m_ovf[1][c]; end
    cmp({tag, ".rdata.wrap"}, rdata0, m_cnt[0][raddr]);
    cmp({tag, ".rdata.sat"},  rdata1, m_cnt[1][raddr]);
    cmp({tag, ".ovf.wrap"},   ovf0, e0);
    cmp({tag, ".ovf.sat"},    ovf1, e1);
`ifdef COUNTER_BANK_IRQ_EN
    cmp({tag, ".irq.wrap"}, irq0, m_irq[0]);
    cmp({tag, ".irq.sat"},  irq1, m_irq[1]);
`endif
  endtask

  // Inputs are set just after a falling edge; one call = one rising edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input bit is_lim, input int ch, input int val);
    en = '0; we = 1'b1; wlim = is_lim; waddr = 2'(ch); wdata = 16'(val);
    cycle("write");
    we = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  en, up;
    logic        we, wlim;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [3:0]  exp_ovf;
  } vec_t;

  initial begin
    vec_t tbl[6];
    tbl[0] = '{4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 16'd3, 16'd0, 4'h0};
    tbl[1] = '{4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 16'd1, 4'h0};
    tbl[2] = '{4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 16'd2, 4'h0};
    tbl[3] = '{4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 16'd3, 4'h0};
    tbl[4] = '{4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 4'h1};
    tbl[5] = '{4'h1, 4'hF, 1'b0, 1'b0, 2'd0, 16'd0, 16'd1, 4'h0};

    do_reset();
    for (int r = 0; r < 4; r++) begin
      raddr = 2'(r);
      #1 cmp("reset.rdata", rdata0, 16'h0);
    end
    cmp("reset.ovf", ovf0, 4'h0);

    // Wrap-up through limit 3 on channel 0
    raddr = 2'd0;
    for (int i = 0; i < 6; i++) begin
      en = tbl[i].en; up = tbl[i].up; we = tbl[i].we; wlim = tbl[i].wlim;
      waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      cycle("table");
      cmp($sformatf("table%0d.rdata", i), rdata0, tbl[i].exp_rdata);
      cmp($sformatf("table%0d.ovf", i),   ovf0,   tbl[i].exp_ovf);
    end
    we = 1'b0;

    // Down-count through zero on channel 1
    wr(1, 1, 5); wr(0, 1, 1);
    raddr = 2'd1; en = 4'b0010; up = 4'b0000;
    cycle("down1");
    cmp("down1.wrap", rdata0, 16'd0); cmp("down1.ovf", ovf0, 4'h0);
    cycle("down2");
    cmp("down2.wrap", rdata0, 16'd5); cmp("down2.ovf", ovf0, 4'b0010);
    cmp("down2.sat", rdata1, 16'd0);  cmp("down2.ovfsat", ovf1, 4'b0010);
    cycle("down3");
    cmp("down3.wrap", rdata0, 16'd4); cmp("down3.ovf", ovf0, 4'h0);
    cmp("down3.ovfsat", ovf1, 4'b0010);

    // Count write wins over enable on channel 2
    en = 4'b0100; up = 4'hF; we = 1'b1; wlim = 1'b0; waddr = 2'd2; wdata = 16'h00AA; raddr = 2'd2;
    cycle("cntwr");
    cmp("cntwr.rdata", rdata0, 16'h00AA); cmp("cntwr.ovf", ovf0, 4'h0);
    we = 1'b0;
    cycle("cntwr_next");

    // Count above limit on channel 3
    wr(1, 3, 2); wr(0, 3, 9);
    raddr = 2'd3; en = 4'b1000; up = 4'hF;
    cycle("above");
    cmp("above.wrap", rdata0, 16'd0); cmp("above.ovf", ovf0, 4'b1000);
    cmp("above.sat", rdata1, 16'd9);  cmp("above.ovfsat", ovf1, 4'b1000);

    // Asynchronous reset while a boundary pulse is pending
    wr(1, 0, 0);
    en = 4'b0001; up = 4'hF; raddr = 2'd0;
    cycle("lim0");
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    model_reset();
    for (int r = 0; r < 4; r++) begin
      raddr = 2'(r);
      #1 cmp("async.rdata.wrap", rdata0, 16'h0);
      cmp("async.rdata.sat", rdata1, 16'h0);
    end
    cmp("async.ovf.wrap", ovf0, 4'h0);
    cmp("async.ovf.sat",  ovf1, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 4'hF; up = 4'h0; raddr = 2'd0;
    cycle("postrst");
    cmp("postrst.lim", rdata0, 16'hFFFF); cmp("postrst.ovf", ovf0, 4'hF);

`ifdef COUNTER_BANK_IRQ_EN
    do_reset();
    en = 4'b0001; up = 4'h0;
    cycle("irq_ev");
    en = 4'h0; irq_clr = 4'b0001;
    cycle("irq_setwins");
    cmp("irq.setwins", irq0, 1'b1);
    cycle("irq_clr");
    cmp("irq.cleared", irq0, 1'b0);
    irq_clr = 4'h0;
`endif

    // Randomized traffic with small limits so boundaries are frequent
    for (int i = 0; i < 400; i++) begin
      en = 4'($urandom); up = 4'($urandom);
      we = ($urandom_range(0, 3) == 0); wlim = 1'($urandom);
      waddr = 2'($urandom); raddr = 2'($urandom);
      wdata = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
`ifdef COUNTER_BANK_IRQ_EN
      irq_clr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
`endif
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
